// File: rtl/reg_wr_arbiter.sv
// Write arbiter between two register-space writers and the single register-file
// write port: one holding slot per port, round-robin on conflicts, same-address coalescing.
module reg_wr_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_done,
    output logic          a_busy,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_done,
    output logic          b_busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_src
);

    // Index 0 is port A, index 1 is port B throughout.
    logic [1:0]    req_w;
    logic [AW-1:0] addr_w [2];
    logic [DW-1:0] data_w [2];

    assign req_w     = {b_req, a_req};
    assign addr_w[0] = a_addr;
    assign addr_w[1] = b_addr;
    assign data_w[0] = a_wdata;
    assign data_w[1] = b_wdata;

    logic [1:0]    valid_q, valid_d;
    logic [AW-1:0] addr_q [2];
    logic [AW-1:0] addr_d [2];
    logic [DW-1:0] data_q [2];
    logic [DW-1:0] data_d [2];
    logic          newer_q, newer_d;
    logic          prio_q, prio_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    done_q, done_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          wr_src_q, wr_src_d;

    logic [1:0] grant;
    logic [1:0] cap;
    logic       coalesce;
    logic       sel;

    always_comb begin
        coalesce = (&valid_q) && (addr_q[0] == addr_q[1]);
        prio_d   = prio_q;
        if (coalesce) begin
            grant = 2'b11;
        end else if (&valid_q) begin
            grant  = prio_q ? 2'b10 : 2'b01;
            prio_d = ~prio_q;
        end else begin
            grant = valid_q;
        end
    end

    // A slot may be refilled at the same edge it is granted, giving one write per cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_comb begin
            cap[gi]     = req_w[gi] & (~valid_q[gi] | grant[gi]);
            valid_d[gi] = cap[gi] | (valid_q[gi] & ~grant[gi]);
            addr_d[gi]  = cap[gi] ? addr_w[gi] : addr_q[gi];
            data_d[gi]  = cap[gi] ? data_w[gi] : data_q[gi];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q[gi] <= 1'b0;
                addr_q[gi]  <= '0;
                data_q[gi]  <= '0;
            end else begin
                valid_q[gi] <= valid_d[gi];
                addr_q[gi]  <= addr_d[gi];
                data_q[gi]  <= data_d[gi];
            end
        end
    end

    always_comb begin
        ack_d   = cap;
        done_d  = grant;
        wr_en_d = |grant;
        // On coalesce the newest capture supplies the data; otherwise the single granted slot.
        sel     = coalesce ? newer_q : grant[1];
        if (|grant) begin
            wr_addr_d = addr_q[sel];
            wr_data_d = data_q[sel];
            wr_src_d  = sel;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
            wr_src_d  = wr_src_q;
        end
        if (cap[1])      newer_d = 1'b1;
        else if (cap[0]) newer_d = 1'b0;
        else             newer_d = newer_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            newer_q   <= 1'b1;
            prio_q    <= 1'b1;
            ack_q     <= 2'b00;
            done_q    <= 2'b00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= 1'b0;
        end else begin
            newer_q   <= newer_d;
            prio_q    <= prio_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    assign a_ack   = ack_q[0];
    assign b_ack   = ack_q[1];
    assign a_done  = done_q[0];
    assign b_done  = done_q[1];
    assign a_busy  = valid_q[0];
    assign b_busy  = valid_q[1];
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Write arbiter for the shared 256×16 register space. It sits between the two register-space writers, the two-wire slave (port A) and the register-interface slave (port B), and the single register-file write port. Each port has a one-entry holding slot. Simultaneous writes are resolved by round-robin, and same-address writes are coalesced so the newest data wins. Both requesters get a bounded wait, and the register file sees at most one write per cycle.

## Interface
- AW, 8, register address width
- DW, 16, register data width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- a_req  in  1  port A write request (level)
- a_addr  in  AW  port A write address
- a_wdata  in  DW  port A write data
- a_ack  out  1  one-cycle pulse: port A request captured into slot
- a_done  out  1  one-cycle pulse: port A slot written (or coalesced)
- a_busy  out  1  port A slot occupied
- b_req, b_addr, b_wdata, b_ack, b_done, b_busy: same as port A, for port B
- wr_en  out  1  register-file write strobe
- wr_addr  out  AW  register-file write address
- wr_data  out  DW  register-file write data
- wr_src  out  1  source of current write (0=A, 1=B)

## Operation
- Each port has a slot (valid, addr, data) and an age flag; `newer` marks which slot was captured last.
- Capture rule per port:
  - Capture at edge if req=1 and the slot is either empty or being granted at that same edge.
  - Capture registers addr/wdata and pulses ack for the following cycle.
  - req=1 with the slot full and not granted: no capture, no ack. The requester holds req/addr/wdata until ack.
- newer update:
  - A captures alone: newer=A.
  - B captures alone: newer=B.
  - Both capture at the same edge: newer=B.
- Arbitration at each edge, evaluated on the current slot state:
  - No slot valid: wr_en=0 next cycle.
  - One slot valid: grant it. prio unchanged.
  - Both valid, addresses differ: grant the port selected by prio, then toggle prio. The loser is granted on the next edge.
  - Both valid, same address: coalesce.
    - wr_addr = common address; wr_data = newer slot's data; wr_src = newer.
    - Both slots cleared; both done pulse; prio unchanged.
- Grant effects, registered:
  - wr_en=1, wr_addr/wr_data/wr_src from the granted slot.
  - Granted port's done=1 for one cycle.
  - Slot cleared unless refilled by a same-edge capture.
- busy = slot valid, registered.

## Timing
- Reset (rst=1 at an edge): all slots invalid, wr_en=0, wr_addr=0, wr_data=0, wr_src=0, all ack/done/busy=0, prio=B, newer=B.
- Reset asserted mid-operation discards pending slot contents. No write and no done is issued for discarded entries.
- Latency, uncontended:
  - req sampled at edge k → ack and busy high in cycle k+1.
  - Granted at edge k+1 → wr_en and done high in cycle k+2.
- Throughput: one write per cycle per port when uncontended, since a same-edge grant and capture is allowed.
- Contended with different addresses: the loser waits exactly one extra cycle. Worst case req-to-wr_en is 3 edges, so there is no starvation.
- wr_en is never high two cycles in a row for the same slot entry.
- done for a port never coincides with ack for the same entry.
- All outputs are registered. There are no combinational paths from req to any output.

## Test plan
- Reset, then A writes addr 0x10 data 0x1234 → a_ack in cycle 1; wr_en=1, wr_addr=0x10, wr_data=0x1234, wr_src=0, a_done=1 in cycle 2.
- A and B request at the same edge, addr 0x01 / 0x02 → cycle 2: wr_src=1 (reset prio=B), addr 0x02. Cycle 3: wr_src=0, addr 0x01. prio ends at A.
- Repeat the same-edge request with different addresses → A granted first this time, confirming prio toggles.
- B captures addr 0x20 data 0xAAAA one edge before A captures addr 0x20 data 0x5555 while B is blocked. Alternatively, both capture at the same edge with B data 0xBBBB → a single wr_en carries the newer data (0x5555 in the first case, 0xBBBB in the second); a_done and b_done pulse together.
- A holds req for 4 consecutive writes (0x00–0x03) uncontended → ack every cycle, wr_en in 4 consecutive cycles, addresses in order.
- rst asserted with both slots valid → next cycle wr_en=0, busy=0, no done pulses. The first post-reset contended pair is granted to B first.
